// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : core/debug single-port memory arbiter with ordered reads.
// Optional starvation guard enabled by ARB_STARVE_GUARD_EN.   Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic [3:0]  c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic [3:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        core_stall
);

  logic                  w_force_dbg;
  logic                  w_c_gnt;
  logic                  w_d_gnt;
  logic                  w_issue_rd;
  logic                  w_ret_vld;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] own_q, own_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int c_cnt_w = $clog2(STARVE_LIMIT + 1);

  logic [c_cnt_w-1:0] starve_cnt_q, starve_cnt_d;

  assign w_force_dbg = d_req && (starve_cnt_q == c_cnt_w'(STARVE_LIMIT));

  // Saturates at the limit; any debug grant or idle debug port restarts it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!d_req || w_d_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != c_cnt_w'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic [31:0] w_unused_limit;
  assign w_unused_limit = 32'(STARVE_LIMIT);
  assign w_force_dbg    = 1'b0;
`endif

  // Core wins unless the starvation guard hands this cycle to debug.
  assign w_c_gnt    = rst_n && c_req && !w_force_dbg;
  assign w_d_gnt    = rst_n && d_req && !w_c_gnt;
  assign w_issue_rd = (w_c_gnt && (c_we == 4'h0)) || (w_d_gnt && (d_we == 4'h0));

  assign c_gnt      = w_c_gnt;
  assign d_gnt      = w_d_gnt;
  assign core_stall = c_req && !w_c_gnt;

  assign m_en    = w_c_gnt || w_d_gnt;
  assign m_we    = w_c_gnt ? c_we : (w_d_gnt ? d_we : 4'h0);
  assign m_addr  = w_d_gnt ? d_addr  : c_addr;
  assign m_wdata = w_d_gnt ? d_wdata : c_wdata;

  // Owner tag pipeline: bit 0 enters on issue, top bit retires; own=1 is debug.
  always_comb begin
    vld_d    = '0;
    own_d    = '0;
    vld_d[0] = w_issue_rd;
    own_d[0] = w_d_gnt;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  assign w_ret_vld = rst_n && vld_q[RD_LATENCY-1];
  assign c_rvalid  = w_ret_vld && !own_q[RD_LATENCY-1];
  assign d_rvalid  = w_ret_vld &&  own_q[RD_LATENCY-1];
  assign c_rdata   = c_rvalid ? m_rdata : 32'h0;
  assign d_rdata   = d_rvalid ? m_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : randomized bench for mem_port_arbiter at read
// latencies 1 and 3, checked against a cycle-indexed response model.
// ============================================================================
module tb_mem_port_arbiter;

  localparam int STARVE = 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        c_req, d_req;
  logic [3:0]  c_we, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, m_rdata;

  logic        c_gnt1, d_gnt1, c_rvalid1, d_rvalid1, m_en1, core_stall1;
  logic [3:0]  m_we1;
  logic [31:0] c_rdata1, d_rdata1, m_addr1, m_wdata1;
  logic        c_gnt3, d_gnt3, c_rvalid3, d_rvalid3, m_en3, core_stall3;
  logic [3:0]  m_we3;
  logic [31:0] c_rdata3, d_rdata3, m_addr3, m_wdata3;

  mem_port_arbiter #(.RD_LATENCY(1), .STARVE_LIMIT(STARVE)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt1), .c_rvalid(c_rvalid1), .c_rdata(c_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_rdata(m_rdata), .core_stall(core_stall1)
  );

  mem_port_arbiter #(.RD_LATENCY(3), .STARVE_LIMIT(STARVE)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt3), .c_rvalid(c_rvalid3), .c_rdata(c_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3),
    .m_rdata(m_rdata), .core_stall(core_stall3)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: expected responder per absolute cycle (0 none, 1 core, 2 debug).
  int         cyc    = 0;
  int         starve = 0;
  logic       c_pend = 1'b0;
  logic       d_pend = 1'b0;
  logic [1:0] resp1 [16] = '{default: 2'd0};
  logic [1:0] resp3 [16] = '{default: 2'd0};
  logic       eg_force, eg_c, eg_d, eg_rd;

  always_comb begin
    eg_force = GUARD && (starve == STARVE) && d_req;
    eg_c     = rst_n && c_req && !eg_force;
    eg_d     = rst_n && d_req && !eg_c;
    eg_rd    = (eg_c && (c_we == 4'h0)) || (eg_d && (d_we == 4'h0));
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        resp1[i] <= 2'd0;
        resp3[i] <= 2'd0;
      end
      starve <= 0;
    end else begin
      resp1[4'(cyc)] <= 2'd0;
      resp3[4'(cyc)] <= 2'd0;
      if (eg_rd) begin
        resp1[4'(cyc + 1)] <= eg_d ? 2'd2 : 2'd1;
        resp3[4'(cyc + 3)] <= eg_d ? 2'd2 : 2'd1;
      end
      starve <= (!d_req || eg_d) ? 0 : ((starve < STARVE) ? starve + 1 : starve);
    end
    cyc    <= cyc + 1;
    c_pend <= c_req && !eg_c;
    d_pend <= d_req && !eg_d;
  end

  function automatic logic [137:0] exp_vec(input int lat);
    logic [1:0]  own;
    logic        cv, dv;
    logic [3:0]  we;
    logic [31:0] a, w;
    own = (lat == 1) ? resp1[4'(cyc)] : resp3[4'(cyc)];
    cv  = rst_n && (own == 2'd1);
    dv  = rst_n && (own == 2'd2);
    we  = eg_c ? c_we    : (eg_d ? d_we    : 4'h0);
    a   = eg_c ? c_addr  : (eg_d ? d_addr  : 32'h0);
    w   = eg_c ? c_wdata : (eg_d ? d_wdata : 32'h0);
    return {eg_c, eg_d, c_req && !eg_c, eg_c || eg_d, we, a, w,
            cv, cv ? m_rdata : 32'h0, dv, dv ? m_rdata : 32'h0};
  endfunction

  logic [137:0] obs1, obs3;
  assign obs1 = {c_gnt1, d_gnt1, core_stall1, m_en1, m_we1,
                 m_en1 ? m_addr1 : 32'h0, m_en1 ? m_wdata1 : 32'h0,
                 c_rvalid1, c_rdata1, d_rvalid1, d_rdata1};
  assign obs3 = {c_gnt3, d_gnt3, core_stall3, m_en3, m_we3,
                 m_en3 ? m_addr3 : 32'h0, m_en3 ? m_wdata3 : 32'h0,
                 c_rvalid3, c_rdata3, d_rvalid3, d_rdata3};

  task automatic set_idle();
    c_req = 1'b0; c_we = 4'h0; c_addr = 32'h0; c_wdata = 32'h0;
    d_req = 1'b0; d_we = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    m_rdata = $urandom;
  endtask

  // A pending (ungranted) request either holds its operands or is withdrawn.
  task automatic drive_rand();
    if (c_pend) begin
      if ($urandom_range(0, 3) == 0) c_req = 1'b0;
    end else begin
      c_req   = ($urandom_range(0, 1) == 1);
      c_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      c_addr  = $urandom;
      c_wdata = $urandom;
    end
    if (d_pend) begin
      if ($urandom_range(0, 3) == 0) d_req = 1'b0;
    end else begin
      d_req   = ($urandom_range(0, 1) == 1);
      d_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    m_rdata = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (t >= 4) begin rst_n = 1'b1; set_idle(); end else drive_rand();
      @(negedge clk);
      vectors++;
      if (obs1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL reset_l1 t=%0d: got %h want %h", t, obs1, exp_vec(1));
      end
      vectors++;
      if (obs3 !== exp_vec(3)) begin
        miscompares++;
        $display("FAIL reset_l3 t=%0d: got %h want %h", t, obs3, exp_vec(3));
      end
      vectors++;
      if ({c_gnt1, d_gnt1, m_en1, m_we1, c_rvalid1, d_rvalid1, c_gnt3, d_gnt3, m_en3, c_rvalid3, d_rvalid3} !== 14'h0) begin
        miscompares++;
        $display("FAIL reset_outputs_zero t=%0d: got %b want 0", t,
                 {c_gnt1, d_gnt1, m_en1, m_we1, c_rvalid1, d_rvalid1, c_gnt3, d_gnt3, m_en3, c_rvalid3, d_rvalid3});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_core_read();
    for (int t = 0; t < 5; t++) begin
      set_idle();
      m_rdata = 32'hDEADBEEF;
      if (t == 0) begin c_req = 1'b1; c_we = 4'h0; c_addr = 32'h100; end
      @(negedge clk);
      vectors++;
      if (obs1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL core_read_l1 t=%0d: got %h want %h", t, obs1, exp_vec(1));
      end
      vectors++;
      if (obs3 !== exp_vec(3)) begin
        miscompares++;
        $display("FAIL core_read_l3 t=%0d: got %h want %h", t, obs3, exp_vec(3));
      end
      vectors++;
      if ({c_gnt1, c_rvalid1, c_rdata1, d_rvalid1} !== {t == 0, t == 1, (t == 1) ? 32'hDEADBEEF : 32'h0, 1'b0}) begin
        miscompares++;
        $display("FAIL core_read_direct t=%0d: got gnt=%b rv=%b rd=%h drv=%b", t, c_gnt1, c_rvalid1, c_rdata1, d_rvalid1);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_simultaneous();
    for (int t = 0; t < 5; t++) begin
      set_idle();
      if (t == 0) begin c_req = 1'b1; c_we = 4'h0; c_addr = 32'h10; end
      if (t <= 1) begin d_req = 1'b1; d_we = 4'hF; d_addr = 32'h20; d_wdata = 32'h55; end
      @(negedge clk);
      vectors++;
      if (obs1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL simul_l1 t=%0d: got %h want %h", t, obs1, exp_vec(1));
      end
      vectors++;
      if (obs3 !== exp_vec(3)) begin
        miscompares++;
        $display("FAIL simul_l3 t=%0d: got %h want %h", t, obs3, exp_vec(3));
      end
      vectors++;
      if ({c_gnt1, core_stall1, d_gnt1, c_rvalid1, d_rvalid1} !== {t == 0, 1'b0, t == 1, t == 1, 1'b0}) begin
        miscompares++;
        $display("FAIL simul_direct t=%0d: got cg=%b st=%b dg=%b crv=%b drv=%b", t, c_gnt1, core_stall1, d_gnt1, c_rvalid1, d_rvalid1);
      end
      if (t == 1) begin
        vectors++;
        if ({m_en1, m_we1, m_addr1, m_wdata1} !== {1'b1, 4'hF, 32'h20, 32'h55}) begin
          miscompares++;
          $display("FAIL simul_dbg_write: got en=%b we=%h a=%h d=%h want 1 f 20 55", m_en1, m_we1, m_addr1, m_wdata1);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_pipeline();
    logic c_exp, d_exp;
    for (int t = 0; t < 9; t++) begin
      set_idle();
      if (t < 4) begin
        if (t % 2 == 0) begin c_req = 1'b1; c_addr = $urandom; end
        else            begin d_req = 1'b1; d_addr = $urandom; end
      end
      @(negedge clk);
      vectors++;
      if (obs1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL pipe_l1 t=%0d: got %h want %h", t, obs1, exp_vec(1));
      end
      vectors++;
      if (obs3 !== exp_vec(3)) begin
        miscompares++;
        $display("FAIL pipe_l3 t=%0d: got %h want %h", t, obs3, exp_vec(3));
      end
      c_exp = (t >= 3) && (t <= 6) && ((t - 3) % 2 == 0);
      d_exp = (t >= 3) && (t <= 6) && ((t - 3) % 2 == 1);
      vectors++;
      if ({c_rvalid3, d_rvalid3} !== {c_exp, d_exp}) begin
        miscompares++;
        $display("FAIL pipe_order_l3 t=%0d: got c=%b d=%b want c=%b d=%b", t, c_rvalid3, d_rvalid3, c_exp, d_exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_starvation();
    logic dg_exp;
    int   d_grants;
    d_grants = 0;
    for (int t = 0; t < 25; t++) begin
      set_idle();
      if (t >= 1 && t <= 20) begin
        c_req = 1'b1; c_we = 4'h0; c_addr = 32'h40 + 32'(t);
        d_req = 1'b1; d_we = 4'h3; d_addr = 32'h80; d_wdata = 32'hA5A5;
      end
      @(negedge clk);
      vectors++;
      if (obs1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL starve_l1 t=%0d: got %h want %h", t, obs1, exp_vec(1));
      end
      vectors++;
      if (obs3 !== exp_vec(3)) begin
        miscompares++;
        $display("FAIL starve_l3 t=%0d: got %h want %h", t, obs3, exp_vec(3));
      end
      if (t >= 1 && t <= 20) begin
        dg_exp = GUARD && ((t - 1 == 8) || (t - 1 == 17));
        vectors++;
        if ({d_gnt1, c_gnt1, core_stall1} !== {dg_exp, !dg_exp, dg_exp}) begin
          miscompares++;
          $display("FAIL starve_direct k=%0d: got dg=%b cg=%b st=%b want dg=%b", t - 1, d_gnt1, c_gnt1, core_stall1, dg_exp);
        end
        if (d_gnt1) d_grants++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (d_grants !== (GUARD ? 2 : 0)) begin
      miscompares++;
      $display("FAIL starve_count: got %0d debug grants want %0d", d_grants, GUARD ? 2 : 0);
    end
  endtask

  task automatic test_reset_midflight();
    for (int t = 0; t < 7; t++) begin
      set_idle();
      rst_n = (t != 1);
      if (t == 0) begin c_req = 1'b1; c_addr = 32'h200; end
      @(negedge clk);
      vectors++;
      if (obs1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL midreset_l1 t=%0d: got %h want %h", t, obs1, exp_vec(1));
      end
      vectors++;
      if (obs3 !== exp_vec(3)) begin
        miscompares++;
        $display("FAIL midreset_l3 t=%0d: got %h want %h", t, obs3, exp_vec(3));
      end
      if (t >= 1) begin
        vectors++;
        if ({c_rvalid1, c_rvalid3, d_rvalid3, c_rdata3, m_en3, m_we3, c_gnt3, core_stall3} !== 43'h0) begin
          miscompares++;
          $display("FAIL midreset_quiet t=%0d: got crv1=%b crv3=%b drv3=%b rd=%h en=%b", t, c_rvalid1, c_rvalid3, d_rvalid3, c_rdata3, m_en3);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive_rand();
      @(negedge clk);
      vectors++;
      if (obs1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL random_l1 t=%0d: got %h want %h", t, obs1, exp_vec(1));
      end
      vectors++;
      if (obs3 !== exp_vec(3)) begin
        miscompares++;
        $display("FAIL random_l3 t=%0d: got %h want %h", t, obs3, exp_vec(3));
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_core_read();
    test_simultaneous();
    test_pipeline();
    test_starvation();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter RD_LATENCY, default 1, giving the memory read latency in cycles (legal range 1..3).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, giving the consecutive debug-denial count that forces a debug grant.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 c_req  input  1  core data-port request.
REQ-006 c_we  input  4  core byte write enables; 0 means read.
REQ-007 c_addr  input  32  core byte address.
REQ-008 c_wdata  input  32  core write data.
REQ-009 c_gnt  output  1  core request accepted this cycle.
REQ-010 c_rvalid  output  1  core read data valid.
REQ-011 c_rdata  output  32  core read data.
REQ-012 d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata SHALL exist with the same direction, width and meaning as the c_* ports, for the debug/DMA requester.
REQ-013 m_en  output  1  memory access strobe.
REQ-014 m_we  output  4  memory byte write enables.
REQ-015 m_addr  output  32  memory address.
REQ-016 m_wdata  output  32  memory write data.
REQ-017 m_rdata  input  32  memory read data, valid RD_LATENCY cycles after a read strobe.
REQ-018 core_stall  output  1  high when c_req is high and c_gnt is low.

Function
REQ-019 Grant SHALL be combinational in the request cycle: at most one of c_gnt/d_gnt is high per cycle, and a grant only goes to an asserted request.
REQ-020 Baseline priority SHALL be fixed: core over debug.
REQ-021 In a granted cycle, m_en SHALL be 1 and m_we/m_addr/m_wdata SHALL equal the winner's inputs. With no grant, m_en and m_we SHALL be 0.
REQ-022 A requester SHALL hold its request and operands stable until granted. Dropping the request before grant SHALL be legal and SHALL produce no memory access.
REQ-023 For each granted read, an owner tag (core/debug) SHALL enter an RD_LATENCY-deep shift pipeline. Exactly RD_LATENCY cycles later, the owner's rvalid SHALL pulse for one cycle with rdata = m_rdata.
REQ-024 Granted writes SHALL produce no rvalid.
REQ-025 Back-to-back grants SHALL be accepted every cycle. Responses SHALL return in issue order with no bubbles.
REQ-026 c_rdata/d_rdata SHALL be 0 whenever the matching rvalid is low.
REQ-027 A request is "the same cycle" as a response if it is granted while a response is retiring. This case SHALL be handled independently: the issue and the retire occur in the same cycle.
REQ-028 core_stall SHALL be 1 exactly when c_req=1 and c_gnt=0.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL clear the owner pipeline and the starvation counter.
REQ-030 During and after reset, all grants, rvalids, m_en and m_we SHALL be 0.
REQ-031 When reset occurs mid-flight, in-flight read responses SHALL be discarded: no rvalid is issued for them after rst_n returns high.
REQ-032 In the cycle rst_n is low, grants SHALL be forced to 0 even if requests are high.

Configuration
REQ-033 With macro ARB_STARVE_GUARD_EN defined, a saturating counter SHALL increment on each cycle where d_req=1 and d_gnt=0. The counter SHALL clear when d_gnt=1 or d_req=0.
REQ-034 With ARB_STARVE_GUARD_EN defined, once the counter equals STARVE_LIMIT, the next contested cycle SHALL grant debug over core. The counter then clears.
REQ-035 Without ARB_STARVE_GUARD_EN, the counter SHALL not exist and priority SHALL remain strictly core over debug.

Verification
REQ-036 Core read only, RD_LATENCY=1: c_req=1, c_we=0, c_addr=0x100, memory returns 0xDEADBEEF -> c_gnt=1 in cycle 0, c_rvalid=1 with c_rdata=0xDEADBEEF in cycle 1, d_rvalid=0 throughout.
REQ-037 Simultaneous requests, core read 0x10 and debug write 0x20 data 0x55 -> cycle 0 grants core (core_stall=0) and the debug write issues in cycle 1. The core read returns in cycle 1 (RD_LATENCY=1) and no d_rvalid occurs.
REQ-038 Starvation with ARB_STARVE_GUARD_EN, STARVE_LIMIT=8: c_req and d_req both held high -> eight core grants, then d_gnt=1 and core_stall=1 on the 9th cycle, then core grants resume. Without the macro, d_gnt never asserts.
REQ-039 RD_LATENCY=3 pipelining: alternate core/debug reads for 4 consecutive cycles -> rvalids return in cycles 3..6 in issue order, each routed to the correct owner.
REQ-040 Reset mid-flight: RD_LATENCY=3, core read granted, rst_n=0 in the next cycle for 1 cycle -> no c_rvalid afterwards, and all outputs are 0 during reset.
